// File: rtl/wb_port_arbiter.sv
// GPR write-port arbiter: writeback has priority, MDU results queue and drain into idle cycles; WBARB_PERF_EN adds perf counters.
// Latency: WB 1 cycle, MDU accept to write >= 2 cycles; mdu_ready = FIFO not full, wb_hold requests a free port cycle on starvation.
module wb_port_arbiter #(
    parameter int XLEN       = 64,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_en,
    input  logic [4:0]      wb_wd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            mdu_valid,
    output logic            mdu_ready,
    input  logic [4:0]      mdu_wd,
    input  logic [XLEN-1:0] mdu_data,
    input  logic            flush,
    output logic            rf_wen,
    output logic [4:0]      rf_wd,
    output logic [XLEN-1:0] rf_wdata,
    output logic            wb_hold,
    output logic            pend_busy
`ifdef WBARB_PERF_EN
    ,
    output logic [31:0]     perf_conflict,
    output logic [31:0]     perf_hold,
    output logic [31:0]     perf_kill
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [4:0]            r_wd   [FIFO_DEPTH];
    logic [XLEN-1:0]       r_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_vld;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW-1:0]         r_wr_ptr;
    logic [CW-1:0]         r_count;
    logic [SW-1:0]         r_age;
    logic                  r_wb_hold;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_head_vld;
    logic                  w_wb_grant;
    logic                  w_mdu_grant;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_push_vld;
    logic                  w_starved;
    logic [FIFO_DEPTH-1:0] w_kill;

    always_comb begin
        w_empty     = (r_count == '0);
        w_full      = (r_count == CW'(FIFO_DEPTH));
        w_head_vld  = !w_empty && r_vld[r_rd_ptr];
        w_wb_grant  = wb_en && (wb_wd != 5'd0);
        // A flushed head must not reach the regfile in the flush cycle.
        w_mdu_grant = !w_wb_grant && w_head_vld && !flush;
        w_pop       = !w_empty && (w_mdu_grant || !r_vld[r_rd_ptr]);
        w_push      = mdu_valid && !w_full && (mdu_wd != 5'd0) && !flush;
        // A push to the rd being written this cycle is the older value.
        w_push_vld  = !(w_wb_grant && (wb_wd == mdu_wd));
        w_starved   = (r_age == SW'(STARVE_MAX));
        w_kill      = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            w_kill[i] = w_wb_grant && r_vld[i] && (r_wd[i] == wb_wd);
        end
    end

    assign mdu_ready = !w_full;
    assign pend_busy = !w_empty;
    assign wb_hold   = r_wb_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_wd[i]   <= '0;
                r_data[i] <= '0;
            end
            r_vld    <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_vld    <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (w_kill[i] || (w_pop && (AW'(i) == r_rd_ptr))) begin
                    r_vld[i] <= 1'b0;
                end
            end
            if (w_push) begin
                r_wd[r_wr_ptr]   <= mdu_wd;
                r_data[r_wr_ptr] <= mdu_data;
                r_vld[r_wr_ptr]  <= w_push_vld;
                r_wr_ptr         <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_age     <= '0;
            r_wb_hold <= 1'b0;
            rf_wen    <= 1'b0;
            rf_wd     <= '0;
            rf_wdata  <= '0;
        end else begin
            r_wb_hold <= w_starved;
            if (flush || w_pop || w_starved) begin
                r_age <= '0;
            end else if (w_head_vld && !w_mdu_grant) begin
                r_age <= r_age + SW'(1);
            end
            rf_wen <= w_wb_grant || w_mdu_grant;
            if (w_wb_grant) begin
                rf_wd    <= wb_wd;
                rf_wdata <= wb_data;
            end else if (w_mdu_grant) begin
                rf_wd    <= r_wd[r_rd_ptr];
                rf_wdata <= r_data[r_rd_ptr];
            end else begin
                rf_wd    <= '0;
                rf_wdata <= '0;
            end
        end
    end

`ifdef WBARB_PERF_EN
    logic [31:0] w_kill_cnt;

    always_comb begin
        w_kill_cnt = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            w_kill_cnt = w_kill_cnt + 32'(w_kill[i]);
        end
        if (w_push && !w_push_vld) begin
            w_kill_cnt = w_kill_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_conflict <= '0;
            perf_hold     <= '0;
            perf_kill     <= '0;
        end else begin
            perf_conflict <= perf_conflict + 32'(w_wb_grant && w_head_vld);
            perf_hold     <= perf_hold + 32'(w_starved);
            perf_kill     <= perf_kill + w_kill_cnt;
        end
    end
`endif

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Shares the single GPR write port between the writeback stage and the multi-cycle MDU (mul/div) result path. Writeback results have fixed priority. MDU results are buffered in a small FIFO and drained into idle port cycles. A starvation counter raises a hold request so that the pipeline step logic can free one port cycle. WAW ordering is preserved by killing queued MDU results whose rd is overwritten by a newer writeback.

Parameters:
XLEN, 64, data width
FIFO_DEPTH, 2, MDU result buffer entries (power of 2, >=2)
STARVE_MAX, 8, cycles a valid FIFO head may wait before wb_hold is raised

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
wb_en  in  1  writeback stage write request
wb_wd  in  5  writeback rd
wb_data  in  XLEN  writeback data
mdu_valid  in  1  MDU result valid
mdu_ready  out  1  FIFO can accept (= not full)
mdu_wd  in  5  MDU rd
mdu_data  in  XLEN  MDU result
flush  in  1  discard all queued MDU results
rf_wen  out  1  regfile write enable
rf_wd  out  5  regfile write address
rf_wdata  out  XLEN  regfile write data
wb_hold  out  1  request: writeback must not write next cycle
pend_busy  out  1  FIFO holds >=1 entry (valid or killed)

Behaviour:
- Reset (async): FIFO empty, all entries invalid, age=0, rf_wen=0, rf_wd=0, rf_wdata=0, wb_hold=0. pend_busy=0 and mdu_ready=1 (combinational from count).
- Push: mdu_valid & mdu_ready stores {rd,data,valid=1} at tail. An entry with mdu_wd=0 is accepted, then discarded (not stored).
- mdu_ready depends on current count only. There is no push-through-pop when full.
- Grant each cycle, in priority order:
  - wb_en & wb_wd!=0 -> WB granted.
  - Otherwise, if the head entry is valid -> head granted and popped.
- wb_en with wb_wd=0 never writes and leaves the port free for the FIFO.
- A killed (invalid) head is popped without a grant in any cycle, including cycles with a WB grant.
- Outputs are registered: the grant made in cycle t drives rf_* in cycle t+1. rf_wen=0 when there is no grant.
- Latency: WB request to rf_wen is 1 cycle. MDU accept to earliest rf_wen is 2 cycles.
- Kill: a WB grant to rd r invalidates every FIFO entry with wd=r in the same cycle. An MDU push in that cycle with mdu_wd=r is older by definition and is stored invalid.
- Starvation:
  - age increments each cycle the head is valid and not granted, saturating at STARVE_MAX.
  - age clears on pop or flush.
  - wb_hold is registered. It is 1 in the cycle after age==STARVE_MAX, for exactly one cycle, then age restarts from 0.
- During wb_hold=1 the writeback stage guarantees wb_en=0. If wb_en=1 anyway, WB still wins (protocol violation, flagged by bench assertion).
- Flush: FIFO emptied and age cleared at the next edge. A push in the flush cycle is dropped (mdu_ready still shown). A WB grant in the flush cycle proceeds normally.
- Simultaneous push and pop with count < FIFO_DEPTH: both happen, count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Reset mid-operation: queued entries are lost and rf_wen drops immediately.

Optional Feature:
WBARB_PERF_EN.
- Defined: adds outputs perf_conflict (32-bit), perf_hold (32-bit) and perf_kill (32-bit), all reset to 0 and wrapping on overflow.
  - perf_conflict: +1 per cycle with a WB grant while the head is valid.
  - perf_hold: +1 per wb_hold pulse.
  - perf_kill: +1 per entry invalidated.
- Undefined: these ports and counters do not exist. Behaviour is otherwise identical.

Test Plan:
- Idle WB; push x7=0x1234 at cycle 0 -> rf_wen=1, rf_wd=7, rf_wdata=0x1234 at cycle 2; pend_busy=0 at cycle 2.
- wb_en on x3 every cycle, x4=0x55 queued at cycle 0 (STARVE_MAX=8) -> wb_hold=1 for one cycle at cycle 10; bench drops wb_en; rf writes x4=0x55 at cycle 11.
- Queue x5=0xAA, then WB x5=0xBB before it drains -> only x5=0xBB written; entry popped silently; perf_kill=1 when WBARB_PERF_EN.
- Continuous WB; push 2 results -> mdu_ready=0, third mdu_valid held stable; WB stops -> two writes on consecutive cycles, mdu_ready=1 after first pop.
- Push x0=0xFF, and separately wb_en with wb_wd=0 -> rf_wen never asserted; the x0 push leaves pend_busy=0.
- Queue 2 entries, assert flush one cycle -> pend_busy=0 next cycle, no MDU writes. Assert rst mid-drain -> rf_wen=0 asynchronously, mdu_ready=1 after release.
